// File: rtl/sap1_pkg.sv
// sap1_pkg: SAP-1 states, opcodes, control-word bit indices and per-state control words
package sap1_pkg;
  typedef enum logic [2:0] {
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int CP_BIT   = 11;
  localparam int EP_BIT   = 10;
  localparam int LM_N_BIT = 9;
  localparam int CE_N_BIT = 8;
  localparam int LI_N_BIT = 7;
  localparam int EI_N_BIT = 6;
  localparam int LA_N_BIT = 5;
  localparam int EA_BIT   = 4;
  localparam int SU_BIT   = 3;
  localparam int EU_BIT   = 2;
  localparam int LB_N_BIT = 1;
  localparam int LO_N_BIT = 0;
  function automatic logic [11:0] cbit(input int i);
    return 12'(1) << i;
  endfunction
  localparam logic [11:0] CON_IDLE   = cbit(LM_N_BIT) | cbit(CE_N_BIT) | cbit(LI_N_BIT) | cbit(EI_N_BIT) |
                                       cbit(LA_N_BIT) | cbit(LB_N_BIT) | cbit(LO_N_BIT);
  localparam logic [11:0] CON_T1     = (CON_IDLE | cbit(EP_BIT)) & ~cbit(LM_N_BIT);
  localparam logic [11:0] CON_T2     = CON_IDLE | cbit(CP_BIT);
  localparam logic [11:0] CON_T3     = CON_IDLE & ~(cbit(CE_N_BIT) | cbit(LI_N_BIT));
  localparam logic [11:0] CON_T4_MEM = CON_IDLE & ~(cbit(EI_N_BIT) | cbit(LM_N_BIT));
  localparam logic [11:0] CON_T4_OUT = (CON_IDLE | cbit(EA_BIT)) & ~cbit(LO_N_BIT);
  localparam logic [11:0] CON_T5_LDA = CON_IDLE & ~(cbit(CE_N_BIT) | cbit(LA_N_BIT));
  localparam logic [11:0] CON_T5_ALU = CON_IDLE & ~(cbit(CE_N_BIT) | cbit(LB_N_BIT));
  localparam logic [11:0] CON_T6_ADD = (CON_IDLE | cbit(EU_BIT)) & ~cbit(LA_N_BIT);
  localparam logic [11:0] CON_T6_SUB = (CON_IDLE | cbit(EU_BIT) | cbit(SU_BIT)) & ~cbit(LA_N_BIT);
endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: T1-T6 ring with absorbing HALT; SAP1_VARCYCLE_EN ends OUT/NOP after T4 and LDA after T5
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       halt_req,
  output state_t     state_q,
  output logic       hlt
);
  state_t state_d;
  logic   last;
`ifdef SAP1_VARCYCLE_EN
  assign last = state_q == S_T6 || (state_q == S_T5 && opcode == OP_LDA) ||
                (state_q == S_T4 && !(opcode inside {OP_LDA, OP_ADD, OP_SUB}));
`else
  logic unused_opcode;
  assign unused_opcode = ^opcode;
  assign last = state_q == S_T6;
`endif
  always_comb begin
    state_d = state_q == S_HALT || (state_q == S_T4 && halt_req) ? S_HALT :
              last ? S_T1 : state_t'(3'(state_q) + 3'd1);
  end
  always_ff @(posedge clk) begin
    state_q <= !reset ? S_T1 : state_d;
  end
  assign hlt = state_q == S_HALT;
endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 controller-sequencer decoding (T-state, opcode) into the control word; SAP1_VARCYCLE_EN shortens instructions
module sap1_controller
  import sap1_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic        hlt,
  output logic [2:0]  tstate
);
  state_t state;
  logic   mem_op;
  sap1_ring_counter u_ring (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .halt_req (opcode == OP_HLT),
    .state_q  (state),
    .hlt      (hlt)
  );
  assign tstate = state;
  assign mem_op = opcode inside {OP_LDA, OP_ADD, OP_SUB};
  always_comb begin
    con = state == S_T1 ? CON_T1 :
          state == S_T2 ? CON_T2 :
          state == S_T3 ? CON_T3 :
          state == S_T4 ? (mem_op ? CON_T4_MEM : opcode == OP_OUT ? CON_T4_OUT : CON_IDLE) :
          state == S_T5 ? (opcode == OP_LDA ? CON_T5_LDA :
                           opcode == OP_ADD || opcode == OP_SUB ? CON_T5_ALU : CON_IDLE) :
          state == S_T6 ? (opcode == OP_ADD ? CON_T6_ADD : opcode == OP_SUB ? CON_T6_SUB : CON_IDLE) :
          CON_IDLE;
  end
endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: randomized scoreboard bench against an instruction-level micro-program model
module tb_sap1_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [11:0] con;
  logic        hlt;
  logic [2:0]  tstate;
  sap1_controller dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .con    (con),
    .hlt    (hlt),
    .tstate (tstate)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0]  t;
    logic [11:0] c;
    logic        h;
  } exp_t;
  exp_t       q[$];
  logic [4:0] plan[$];
  int         compared = 0;
  int         mismatched = 0;
  int         step = 0;
  bit         halted = 0;
  bit         valid = 0;
  bit         kill = 0;
  logic [3:0] cur_op = 4'h0;
  exp_t       e;
  function automatic int ilen(input logic [3:0] op);
`ifdef SAP1_VARCYCLE_EN
    return (op == 4'h1 || op == 4'h2) ? 6 : op == 4'h0 ? 5 : 4;
`else
    return 6;
`endif
  endfunction
  function automatic logic [11:0] word(input int s, input logic [3:0] op);
    logic [11:0] ex [3];
    case (op)
      4'h0:    ex = '{12'h1A3, 12'h2C3, 12'h3E3};
      4'h1:    ex = '{12'h1A3, 12'h2E1, 12'h3C7};
      4'h2:    ex = '{12'h1A3, 12'h2E1, 12'h3CF};
      4'hE:    ex = '{12'h3F2, 12'h3E3, 12'h3E3};
      default: ex = '{12'h3E3, 12'h3E3, 12'h3E3};
    endcase
    return s == 0 ? 12'h5E3 : s == 1 ? 12'hBE3 : s == 2 ? 12'h263 : ex[s-3];
  endfunction
  function automatic logic [3:0] pick();
    int r = int'($urandom_range(0, 19));
    return r < 4 ? 4'h0 : r < 8 ? 4'h1 : r < 12 ? 4'h2 : r < 15 ? 4'hE : r == 15 ? 4'hF :
           4'($urandom_range(3, 13));
  endfunction
  task automatic chk(input string n, input logic [11:0] got, input logic [11:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, got, want);
    end
  endtask
  task automatic cyc(input logic r, input logic [3:0] op);
    reset = r;
    opcode = op;
    if (valid)
      q.push_back(halted ? exp_t'{3'd7, 12'h3E3, 1'b1} : exp_t'{3'(step + 1), word(step, op), 1'b0});
    @(posedge clk);
    if (!r) begin
      step = 0;
      halted = 0;
      valid = 1;
    end else if (valid && !halted) begin
      if (step == 3 && op == 4'hF) halted = 1;
      else step = step + 1 == ilen(op) ? 0 : step + 1;
    end
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("tstate", 12'(tstate), 12'(e.t));
      chk("con", con, e.c);
      chk("hlt", 12'(hlt), 12'(e.h));
    end
  end
  initial begin
    int hc = 0;
    plan = '{5'h00, 5'h01, 5'h02, 5'h0E, 5'h05, 5'h0F, 5'h11};
    cyc(1'b0, 4'($urandom));
    cyc(1'b0, 4'($urandom));
    for (int i = 0; i < 3000; i++) begin
      logic       r = 1'b1;
      logic [3:0] op = 4'($urandom);
      if (halted) begin
        hc++;
        if (hc > 20) begin
          r = 1'b0;
          hc = 0;
        end
      end else begin
        if (step >= 3) begin
          op = cur_op;
          if (step == 4 && kill) begin
            r = 1'b0;
            kill = 0;
          end
        end else if (step == 2) begin
          if (plan.size() > 0) {kill, cur_op} = plan.pop_front();
          else cur_op = pick();
        end
        if (plan.size() == 0 && !kill && $urandom_range(0, 80) == 0) r = 1'b0;
      end
      cyc(r, op);
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
